// File: rtl/ifetch_buffer_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package ifetch_buffer_pkg;
    localparam int XLEN_DEF = 32;
    localparam int INSTR_W  = 32;
    localparam int PC_STEP  = 4;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [INSTR_W-1:0]  ir;
    } ifb_entry_t;
endpackage

// File: rtl/ifetch_buffer_if.sv
// Fetch-side bundle: redirect in, memory request/response, decode output channel.
interface ifetch_buffer_if
    import ifetch_buffer_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [XLEN-1:0]    mem_req_addr;
    logic               mem_rsp_valid;
    logic [INSTR_W-1:0] mem_rsp_data;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    out_pc;
    logic [INSTR_W-1:0] out_ir;

    // master = the prefetch unit, slave = memory + decode + branch unit
    modport master (
        input  redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready,
        output mem_req_valid, mem_req_addr, out_valid, out_pc, out_ir
    );
    modport slave (
        output redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready,
        input  mem_req_valid, mem_req_addr, out_valid, out_pc, out_ir
    );
endinterface

// File: rtl/ifetch_buffer_fifo.sv
// Synchronous FIFO of fetched {pc, ir} entries; head is the registered oldest entry.
module ifetch_buffer_fifo
    import ifetch_buffer_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = ifb_entry_t,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  T          din,
    output T          head,
    output logic [AW:0] count
);
    T            mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Extra pointer bit distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;
endmodule

// File: rtl/ifetch_buffer.sv
// Instruction prefetch buffer: credit-limited pipelined fetch, in-order queue, redirect flush.
// Optional IFB_PERF_EN adds perf_empty_cyc / perf_flushes saturating counters.
module ifetch_buffer
    import ifetch_buffer_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic clk,
    input  logic rst,
    ifetch_buffer_if.master bus
`ifdef IFB_PERF_EN
    ,
    output logic [31:0] perf_empty_cyc,
    output logic [31:0] perf_flushes
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] ir;
    } entry_t;

    logic [XLEN-1:0] fetch_pc, rsp_pc, redir_pc;
    logic [CW-1:0]   inflight, drop, count;
    logic [CW-1:0]   inflight_n, drop_n;
    entry_t          head, push_entry;
    logic            redirect, credit, req_valid, req_fire;
    logic            rsp_acc, rsp_drop, push, pop, out_valid;
    logic            unused_pc_lsb;

    assign redirect      = bus.redirect_valid;
    assign redir_pc      = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign unused_pc_lsb = ^bus.redirect_pc[1:0];

    // Queued + outstanding never exceeds DEPTH, so responses always find a slot.
    assign credit    = ({1'b0, count} + {1'b0, inflight}) < (CW+1)'(DEPTH);
    assign req_valid = !rst && !redirect && credit;
    assign req_fire  = req_valid && bus.mem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_acc  = !rst && bus.mem_rsp_valid && (inflight != '0);
    assign rsp_drop = rsp_acc && (drop != '0);
    assign push     = rsp_acc && (drop == '0) && !redirect;

    assign out_valid = !rst && (count != '0) && !redirect;
    assign pop       = out_valid && bus.out_ready;

    assign push_entry.pc = rsp_pc;
    assign push_entry.ir = bus.mem_rsp_data;

    always_comb begin
        inflight_n = inflight + CW'(req_fire) - CW'(rsp_acc);
        drop_n     = drop - CW'(rsp_drop);
        // Everything still outstanding after this cycle's response is wrong-path.
        if (redirect) drop_n = drop_n + inflight_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight_n;
            drop     <= drop_n;
            if (redirect) begin
                fetch_pc <= redir_pc;
                rsp_pc   <= redir_pc;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + XLEN'(PC_STEP);
                if (push)     rsp_pc   <= rsp_pc + XLEN'(PC_STEP);
            end
        end
    end

    ifetch_buffer_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (push_entry),
        .head  (head),
        .count (count)
    );

    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_addr  = fetch_pc;
    assign bus.out_valid     = out_valid;
    assign bus.out_pc        = rst ? '0 : head.pc;
    assign bus.out_ir        = rst ? '0 : head.ir;

`ifdef IFB_PERF_EN
    logic [31:0] empty_q, flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            empty_q <= '0;
            flush_q <= '0;
        end else begin
            if (!out_valid && (empty_q != '1)) empty_q <= empty_q + 32'd1;
            if (redirect && (flush_q != '1))   flush_q <= flush_q + 32'd1;
        end
    end

    assign perf_empty_cyc = rst ? '0 : empty_q;
    assign perf_flushes   = rst ? '0 : flush_q;
`endif

    a_rsp_no_inflight: assert property (@(posedge clk) disable iff (rst)
        !(bus.mem_rsp_valid && (inflight == '0)))
        else $error("ifetch_buffer: response with no request outstanding");
endmodule

// File: tb/tb_ifetch_buffer.sv
// Directed bench for ifetch_buffer with an in-order, fixed-latency memory model.
module tb_ifetch_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifetch_buffer_if #(.XLEN(32)) bus();

`ifdef IFB_PERF_EN
    logic [31:0] perf_empty_cyc, perf_flushes;
`endif

    ifetch_buffer #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef IFB_PERF_EN
        ,
        .perf_empty_cyc (perf_empty_cyc),
        .perf_flushes   (perf_flushes)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] idata(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // memory model: accepted addresses answered in order after lat cycles
    typedef struct { logic [31:0] addr; int due; } pend_t;
    pend_t q[$];
    int cyc   = 0;
    int lat   = 1;
    int n_req = 0;

    always @(posedge clk) begin
        if (rst) q.delete();
        else begin
            if (bus.mem_rsp_valid) void'(q.pop_front());
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                q.push_back('{bus.mem_req_addr, cyc + lat});
                n_req++;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due <= cyc) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = idata(q[0].addr);
        end else begin
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_data  = '0;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.mem_req_ready  = 1'b0;
        bus.out_ready      = 1'b0;
        lat = 1;
        tick();
        tick();
        chk("rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_pc", 64'(bus.out_pc), 64'd0);
        chk("rst_out_ir", 64'(bus.out_ir), 64'd0);
`ifdef IFB_PERF_EN
        chk("rst_perf_empty", 64'(perf_empty_cyc), 64'd0);
        chk("rst_perf_flush", 64'(perf_flushes), 64'd0);
`endif
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_out(input int max_cyc, input string tag);
        int k;
        k = 0;
        while (!bus.out_valid && k < max_cyc) begin
            tick();
            k++;
        end
        if (!bus.out_valid) chk({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        int n0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;

        // 1: latency-1 memory, decode always ready
        do_reset();
        bus.mem_req_ready = 1'b1;
        bus.out_ready     = 1'b1;
        #1;
        chk("t1_first_valid", 64'(bus.mem_req_valid), 64'd1);
        chk("t1_first_addr", 64'(bus.mem_req_addr), 64'h0);
        chk("t1_out_idle", 64'(bus.out_valid), 64'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t1_addr", 64'(bus.mem_req_addr), 64'(32'(4 * (k + 1))));
            if (k >= 1) begin
                chk("t1_out_valid", 64'(bus.out_valid), 64'd1);
                chk("t1_out_pc", 64'(bus.out_pc), 64'(32'(4 * (k - 1))));
                chk("t1_out_ir", 64'(bus.out_ir), 64'(idata(32'(4 * (k - 1)))));
            end else begin
                chk("t1_out_lat", 64'(bus.out_valid), 64'd0);
            end
        end

        // 2: decode stalled, queue fills to DEPTH and stops issuing
        do_reset();
        bus.mem_req_ready = 1'b1;
        n0 = n_req;
        for (int k = 0; k < 8; k++) tick();
        chk("t2_req_count", 64'(n_req - n0), 64'd4);
        chk("t2_req_blocked", 64'(bus.mem_req_valid), 64'd0);
        chk("t2_out_valid", 64'(bus.out_valid), 64'd1);
        chk("t2_head_pc", 64'(bus.out_pc), 64'h0);
        tick();
        chk("t2_still_blocked", 64'(bus.mem_req_valid), 64'd0);
        bus.out_ready = 1'b1;
        tick();
        chk("t2_req_after_pop", 64'(bus.mem_req_valid), 64'd1);
        chk("t2_addr_after_pop", 64'(bus.mem_req_addr), 64'h10);
        chk("t2_pc_after_pop", 64'(bus.out_pc), 64'h4);

        // 3: three requests in flight, redirect to unaligned 0x103
        do_reset();
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h10;
        tick();
        bus.redirect_valid = 1'b0;
        bus.mem_req_ready  = 1'b1;
        lat = 10;
        #1;
        chk("t3_addr_10", 64'(bus.mem_req_addr), 64'h10);
        tick();
        tick();
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h103;
        #1;
        chk("t3_no_req_redirect", 64'(bus.mem_req_valid), 64'd0);
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        chk("t3_req_valid", 64'(bus.mem_req_valid), 64'd1);
        chk("t3_req_addr", 64'(bus.mem_req_addr), 64'h100);
        wait_out(60, "t3_first");
        chk("t3_first_pc", 64'(bus.out_pc), 64'h100);
        chk("t3_first_ir", 64'(bus.out_ir), 64'(idata(32'h100)));
        tick();
        wait_out(60, "t3_second");
        chk("t3_second_pc", 64'(bus.out_pc), 64'h104);

        // 4: redirect in a cycle carrying a response and a pop
        do_reset();
        bus.mem_req_ready = 1'b1;
        bus.out_ready     = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        #1;
        chk("t4_out_masked", 64'(bus.out_valid), 64'd0);
        chk("t4_req_masked", 64'(bus.mem_req_valid), 64'd0);
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        chk("t4_empty_n1", 64'(bus.out_valid), 64'd0);
        chk("t4_req_addr", 64'(bus.mem_req_addr), 64'h200);
        tick();
        chk("t4_empty_n2", 64'(bus.out_valid), 64'd0);
        tick();
        chk("t4_out_valid", 64'(bus.out_valid), 64'd1);
        chk("t4_out_pc", 64'(bus.out_pc), 64'h200);

        // 5: fetch address wraps past the top of the address space
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        chk("t5_addr_top", 64'(bus.mem_req_addr), 64'hFFFF_FFFC);
        tick();
        chk("t5_addr_wrap", 64'(bus.mem_req_addr), 64'h0);
        tick();
        chk("t5_pc_top", 64'(bus.out_pc), 64'hFFFF_FFFC);
        chk("t5_ir_top", 64'(bus.out_ir), 64'(idata(32'hFFFF_FFFC)));
        tick();
        chk("t5_pc_wrap", 64'(bus.out_pc), 64'h0);

`ifdef IFB_PERF_EN
        // 6: 3 redirects, 10 empty cycles after reset
        do_reset();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        tick();
        tick();
        tick();
        bus.redirect_valid = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        chk("t6_flushes", 64'(perf_flushes), 64'd3);
        chk("t6_empty", 64'(perf_empty_cyc), 64'd10);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
